up5bit_counter_rr_sched: RTL and testbench

Round-robin scheduler sharing one 5-bit incrementer between two counter channels, each owned by its own requester, all on a single clock. Each channel's count register is updated only through the shared adder, one channel at a time, under a three-state FSM. It is the controller counterpart of the up5bit dual-counter testcase: the same pair of 5-bit counts, arbitrated instead of free-running, for fabric benchmarking and post-route equivalence.

---
 rtl/up5bit_counter_sched_pkg.sv | 16 +
 rtl/up5bit_counter_rr_sched_rr_arbiter2.sv | 25 ++
 rtl/up5bit_counter_rr_sched.sv | 139 +++++++++++++
 tb/tb_up5bit_counter_rr_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/up5bit_counter_sched_pkg.sv
// Shared types and constants for the round-robin
// dual-channel 5-bit counter scheduler.
package up5bit_counter_sched_pkg;

  localparam int WIDTH_DEFAULT = 5;

  localparam int CH0 = 0;
  localparam int CH1 = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    UPDATE = 2'd2
  } state_e;

endpackage

// File: rtl/up5bit_counter_rr_sched_rr_arbiter2.sv
// Two-way round-robin arbiter; ptr names the
// channel favoured when both requests are live.
module rr_arbiter2
  import up5bit_counter_sched_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req0 && req1): begin
        if (ptr == 1'(CH1)) grant[CH1] = 1'b1;
        else                grant[CH0] = 1'b1;
      end
      (req0 && !req1): grant[CH0] = 1'b1;
      (!req0 && req1): grant[CH1] = 1'b1;
      default:         grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/up5bit_counter_rr_sched.sv
// Two counters sharing one incrementer under a
// three-state grant/sum/update sequencer.
module up5bit_counter_rr_sched
  import up5bit_counter_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             clr0,
  input  logic             clr1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             wrap0,
  output logic             wrap1,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             wrap0_q, wrap0_d;
  logic             wrap1_q, wrap1_d;

  logic             elig0, elig1;
  logic [1:0]       arb_grant;
  logic [WIDTH-1:0] out_sel;

  // A live ack masks its own request for one cycle
  assign elig0 = req0 & ~ack0_q;
  assign elig1 = req1 & ~ack1_q;

  rr_arbiter2 u_arb (
    .req0  (elig0),
    .req1  (elig1),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  assign out_sel = grant_q[CH1] ? out1_q : out0_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    wrap0_d = 1'b0;
    wrap1_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          grant_d = arb_grant;
          state_d = GRANT;
        end
      end
      GRANT: begin
        sum_d   = {1'b0, out_sel}
                + {{WIDTH{1'b0}}, 1'b1};
        state_d = UPDATE;
      end
      UPDATE: begin
        if (grant_q[CH1]) begin
          out1_d  = sum_q[WIDTH-1:0];
          ack1_d  = 1'b1;
          wrap1_d = sum_q[WIDTH];
          ptr_d   = 1'(CH0);
        end else begin
          out0_d  = sum_q[WIDTH-1:0];
          ack0_d  = 1'b1;
          wrap0_d = sum_q[WIDTH];
          ptr_d   = 1'(CH1);
        end
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
    // Clear wins over a same-edge write; the ack still fires
    if (clr0) begin
      out0_d  = '0;
      wrap0_d = 1'b0;
    end
    if (clr1) begin
      out1_d  = '0;
      wrap1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'(CH0);
      sum_q   <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      wrap0_q <= 1'b0;
      wrap1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      wrap0_q <= wrap0_d;
      wrap1_q <= wrap1_d;
    end
  end

  assign out0  = out0_q;
  assign out1  = out1_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign wrap0 = wrap0_q;
  assign wrap1 = wrap1_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_up5bit_counter_rr_sched.sv
// Randomised and directed bench for the scheduler,
// scored against a transaction-level model.
module tb_up5bit_counter_rr_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, clr0, clr1;
  logic       ack0, ack1, wrap0, wrap1, busy;
  logic [4:0] out0, out1;

  up5bit_counter_rr_sched #(.WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .clr0  (clr0),
    .clr1  (clr1),
    .ack0  (ack0),
    .ack1  (ack1),
    .out0  (out0),
    .out1  (out1),
    .wrap0 (wrap0),
    .wrap1 (wrap1),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  // Model: counts, transaction phase (0 idle,
  // 1 granted, 2 sum held), served channel, and the
  // channel served last (the other one is favoured).
  int m_cnt[2];
  bit m_ack[2];
  bit m_wrap[2];
  int phase;
  int mch;
  int mlast;
  int msum;

  task automatic m_reset();
    m_cnt  = '{0, 0};
    m_ack  = '{0, 0};
    m_wrap = '{0, 0};
    phase  = 0;
    mch    = 0;
    mlast  = 1;
    msum   = 0;
  endtask

  task automatic m_edge();
    int nc[2];
    bit na[2];
    bit nw[2];
    bit e0, e1;
    nc = m_cnt;
    na = '{0, 0};
    nw = '{0, 0};
    if (phase == 0) begin
      e0 = req0 && !m_ack[0];
      e1 = req1 && !m_ack[1];
      if (e0 || e1) begin
        if (e0 && e1) mch = 1 - mlast;
        else          mch = e0 ? 0 : 1;
        phase = 1;
      end
    end else if (phase == 1) begin
      msum  = m_cnt[mch] + 1;
      phase = 2;
    end else begin
      nc[mch] = msum % 32;
      na[mch] = 1;
      nw[mch] = (msum == 32) &&
                !(mch == 0 ? clr0 : clr1);
      mlast   = mch;
      phase   = 0;
    end
    if (clr0) nc[0] = 0;
    if (clr1) nc[1] = 0;
    m_cnt  = nc;
    m_ack  = na;
    m_wrap = nw;
  endtask

  task automatic cmp_all();
    chk("out0",  out0,  m_cnt[0]);
    chk("out1",  out1,  m_cnt[1]);
    chk("ack0",  ack0,  m_ack[0]);
    chk("ack1",  ack1,  m_ack[1]);
    chk("wrap0", wrap0, m_wrap[0]);
    chk("wrap1", wrap1, m_wrap[1]);
    chk("busy",  busy,  phase != 0);
  endtask

  task automatic step(input bit r0, input bit r1,
                      input bit c0, input bit c1);
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    clr0 = c0;
    clr1 = c1;
    @(posedge clk);
    m_edge();
    #1;
    cmp_all();
  endtask

  // Async reset mid-cycle, checked before any edge
  task automatic do_reset();
    #2;
    req0  = 1'b0;
    req1  = 1'b0;
    clr0  = 1'b0;
    clr1  = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_out0", out0, 0);
    chk("rst_out1", out1, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);
    m_reset();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic serve(input int ch, input bit c0);
    step(ch == 0, ch == 1, 1'b0, 1'b0);
    step(ch == 0, ch == 1, 1'b0, 1'b0);
    step(ch == 0, ch == 1, c0, 1'b0);
  endtask

  bit r0, r1, c0, c1;

  initial begin
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    clr0  = 1'b0;
    clr1  = 1'b0;
    m_reset();
    do_reset();

    for (int k = 1; k <= 5; k++) begin
      serve(0, 1'b0);
      chk("single_out0", out0, k);
      chk("single_ack0", ack0, 1);
      chk("single_out1", out1, 0);
      step(0, 0, 0, 0);
    end

    do_reset();
    repeat (12) step(1, 1, 0, 0);
    chk("cont_out0", out0, 2);
    chk("cont_out1", out1, 2);
    step(0, 0, 0, 0);

    do_reset();
    for (int k = 1; k <= 32; k++) begin
      serve(1, 1'b0);
      if (k == 31) chk("wrap_pre", out1, 31);
      if (k == 32) begin
        chk("wrap_out1", out1, 0);
        chk("wrap_hi", wrap1, 1);
      end
      step(0, 0, 0, 0);
      if (k == 32) chk("wrap_lo", wrap1, 0);
    end

    do_reset();
    repeat (7) begin
      serve(0, 1'b0);
      step(0, 0, 0, 0);
    end
    chk("coll_pre", out0, 7);
    serve(0, 1'b1);
    chk("coll_out0", out0, 0);
    chk("coll_ack0", ack0, 1);
    chk("coll_wrap0", wrap0, 0);
    step(0, 0, 0, 0);

    do_reset();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    do_reset();
    repeat (4) step(0, 0, 0, 0);
    chk("abort_out1", out1, 0);

    r0 = 0;
    r1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (r0 && m_ack[0]) r0 = 0;
      else if (!r0 && ($urandom % 3 == 0)) r0 = 1;
      if (r1 && m_ack[1]) r1 = 0;
      else if (!r1 && ($urandom % 3 == 0)) r1 = 1;
      c0 = ($urandom % 16 == 0);
      c1 = ($urandom % 16 == 0);
      if ($urandom % 200 == 0) begin
        do_reset();
        r0 = 0;
        r1 = 0;
      end else begin
        step(r0, r1, c0, c1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
